// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the CPU run/step sequencer: FSM state encodings and
// the input synchronizer depth.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/cpu_run_ctrl_btn_cond.sv
// btn_cond: conditions one raw asynchronous input into a single-cycle rising-edge
// pulse. The stability debouncer is present only when CPU_RUN_CTRL_DEBOUNCE_EN is defined.
module btn_cond
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_lvl;
  logic                  clean;
  logic                  clean_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], btn};
    end
  end

  assign sync_lvl = sync_q[SYNC_DEPTH-1];

`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt_q;
  logic             deb_q;

  // The level flips only after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else if (sync_lvl == deb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_q <= '0;
      deb_q     <= sync_lvl;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign clean = deb_q;
`else
  logic deb_unused;

  // Keeps DEB_CYCLES referenced while the debouncer is compiled out.
  assign deb_unused = (DEB_CYCLES > 0);
  assign clean      = sync_lvl;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_prev_q <= 1'b0;
      pulse        <= 1'b0;
    end else begin
      clean_prev_q <= clean;
      pulse        <= clean & ~clean_prev_q;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step sequencer issuing single-cycle CPU clock enables.
// Input debouncing is enabled by defining CPU_RUN_CTRL_DEBOUNCE_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 5_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic                 GO,
  input  logic                 halt,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] step_cnt
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_DIV - 2);

  logic              start_p;
  logic              step_p;
  logic              go_p;
  logic [1:0]        next_state;
  logic [TICK_W-1:0] tick_q;
  logic              expiry;
  logic              en_d;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk(clk), .rst(rst), .btn(start), .pulse(start_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk(clk), .rst(rst), .btn(step), .pulse(step_p)
  );
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_go (
    .clk(clk), .rst(rst), .btn(GO), .pulse(go_p)
  );

  // The expiry cycle is the one in which cpu_en is high in RUN.
  assign expiry = (state == ST_RUN) && (tick_q == TICK_LAST);

  // NOTE: next_state takes its default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_p)     next_state = ST_RUN;
        else if (step_p) next_state = ST_STEP;
      end
      ST_RUN: begin
        if (start_p)               next_state = ST_IDLE;
        else if (expiry && halt)   next_state = ST_HALT;
      end
      ST_STEP: begin
        next_state = halt ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (start_p)     next_state = ST_IDLE;
        else if (go_p)   next_state = ST_RUN;
        else if (step_p) next_state = ST_STEP;
      end
    endcase
  end

  // cpu_en is registered, so it is decided one cycle ahead of the tick reaching TICK_LAST.
  assign en_d = (next_state == ST_STEP) ||
                ((state == ST_RUN) && (next_state == ST_RUN) && (tick_q == TICK_PRE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_q   <= '0;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      state  <= next_state;
      cpu_en <= en_d;
      if ((state == ST_RUN) && (next_state == ST_RUN) && !expiry) begin
        tick_q <= tick_q + 1'b1;
      end else begin
        tick_q <= '0;
      end
      if (cpu_en && (step_cnt != '1)) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random button and
// halt activity, compared every cycle against a behavioural reference model.
module tb_cpu_run_ctrl;

  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int MAXC = 4096;
`ifdef CPU_RUN_CTRL_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = DEB + 3;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 3;
`endif

  typedef enum logic [1:0] {M_IDLE = 2'b00, M_RUN = 2'b01, M_STEP = 2'b10, M_HALT = 2'b11} mstate_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step, go, halt;
  logic        cpu_en, cpu_en3;
  logic [1:0]  state, state3;
  logic [31:0] step_cnt;
  logic [2:0]  cnt3;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit      raw_h [3][MAXC];
  bit      d_h   [3][MAXC];
  int      m;
  mstate_t exp_state;
  bit      exp_en;
  int      exp_cnt;
  int      age;

  cpu_run_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .GO(go), .halt(halt),
    .cpu_en(cpu_en), .state(state), .step_cnt(step_cnt)
  );

  cpu_run_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .step(step), .GO(go), .halt(halt),
    .cpu_en(cpu_en3), .state(state3), .step_cnt(cnt3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit raw_at(input int i, input int idx);
    return (idx < 1) ? 1'b0 : raw_h[i][idx];
  endfunction

  function automatic bit d_at(input int i, input int idx);
    return (idx < 1) ? 1'b0 : d_h[i][idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < MAXC; j++) begin
        raw_h[i][j] = 1'b0;
        d_h[i][j]   = 1'b0;
      end
    end
    m         = 0;
    exp_state = M_IDLE;
    exp_en    = 1'b0;
    exp_cnt   = 0;
    age       = 0;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit      ps [3];
    mstate_t nxt;
    int      nage;
    bit      all_flip;
    m++;
    if (m >= MAXC) begin
      $display("FAIL model_range: observed=%0d expected<%0d", m, MAXC);
      $fatal(1);
    end
    // A button pulse visible before edge m is the debounced level rising two edges earlier.
    for (int i = 0; i < 3; i++) ps[i] = d_at(i, m - 2) & ~d_at(i, m - 3);
    if (exp_en) exp_cnt++;
    nxt  = exp_state;
    nage = 0;
    case (exp_state)
      M_IDLE: if (ps[0]) nxt = M_RUN; else if (ps[1]) nxt = M_STEP;
      M_RUN: begin
        if (ps[0])                nxt = M_IDLE;
        else if (exp_en && halt)  nxt = M_HALT;
        else                      nage = age + 1;
      end
      M_STEP: nxt = halt ? M_HALT : M_IDLE;
      M_HALT: if (ps[0]) nxt = M_IDLE; else if (ps[2]) nxt = M_RUN; else if (ps[1]) nxt = M_STEP;
    endcase
    exp_en    = (nxt == M_STEP) || ((nxt == M_RUN) && ((nage % TICK) == TICK - 1));
    exp_state = nxt;
    age       = nage;
    raw_h[0][m] = start;
    raw_h[1][m] = step;
    raw_h[2][m] = go;
    for (int i = 0; i < 3; i++) begin
      if (DEB_ON) begin
        all_flip = 1'b1;
        for (int j = m - DEB - 1; j <= m - 2; j++) begin
          if (raw_at(i, j) == d_at(i, m - 1)) all_flip = 1'b0;
        end
        d_h[i][m] = all_flip ? ~d_at(i, m - 1) : d_at(i, m - 1);
      end else begin
        d_h[i][m] = raw_at(i, m - 1);
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cpu_en", 32'(cpu_en), 32'(exp_en));
    check("state", 32'(state), 32'(exp_state));
    check("step_cnt", step_cnt, 32'(exp_cnt));
    check("sat_cpu_en", 32'(cpu_en3), 32'(exp_en));
    check("sat_cnt", 32'(cnt3), 32'((exp_cnt > 7) ? 7 : exp_cnt));
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic reset_release();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    int rem [3];
    bit lvl [3];
    int guard;
    rst = 1'b0; start = 1'b0; step = 1'b0; go = 1'b0; halt = 1'b0;
    @(negedge clk);
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_state", 32'(state), 32'(M_IDLE));
    check("reset_step_cnt", step_cnt, 32'd0);
    reset_release();
    run_n(5);

    // Start held 10 cycles, then free-run.
    start = 1'b1; run_n(10); start = 1'b0;
    run_n(20);
    check("run_after_start", 32'(state), 32'(M_RUN));

    // Halt request lands on the next pulse.
    halt = 1'b1; run_n(8); halt = 1'b0;
    check("halted", 32'(state), 32'(M_HALT));
    run_n(6);

    // Step out of HALT, then glitch and a real step from IDLE.
    step = 1'b1; run_n(6); step = 1'b0; run_n(6);
    check("step_from_halt", 32'(state), 32'(M_IDLE));
    step = 1'b1; run_n(2); step = 1'b0; run_n(10);
    step = 1'b1; run_n(6); step = 1'b0; run_n(6);
    check("step_idle_again", 32'(state), 32'(M_IDLE));

    // Run, halt, resume with GO.
    start = 1'b1; run_n(6); start = 1'b0; run_n(4);
    halt = 1'b1; run_n(8); halt = 1'b0;
    go = 1'b1; run_n(6); go = 1'b0; run_n(4);
    check("resumed", 32'(state), 32'(M_RUN));

    // Align a start pulse with a tick expiry.
    guard = 0;
    while (!((exp_state == M_RUN) && (((age + LAT) % TICK) == TICK - 1)) && guard < 2 * TICK) begin
      run_cycle();
      guard++;
    end
    check("align_found", 32'(guard < 2 * TICK), 32'd1);
    start = 1'b1;
    run_n(LAT);
    check("expiry_pulse", 32'(cpu_en), 32'd1);
    check("expiry_state", 32'(state), 32'(M_RUN));
    run_cycle();
    check("expiry_to_idle", 32'(state), 32'(M_IDLE));
    run_n(2); start = 1'b0; run_n(8);

    // Coincident start and step from IDLE.
    start = 1'b1; step = 1'b1; run_n(6); start = 1'b0; step = 1'b0; run_n(2);
    check("start_beats_step", 32'(state), 32'(M_RUN));

    // Random button and halt activity.
    for (int b = 0; b < 3; b++) begin rem[b] = 0; lvl[b] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          rem[b] = lvl[b] ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 12));
        end
        rem[b]--;
      end
      start = lvl[0]; step = lvl[1]; go = lvl[2];
      halt  = ($urandom_range(0, 3) == 0);
      run_cycle();
    end
    start = 1'b0; step = 1'b0; go = 1'b0; halt = 1'b0;

    // Fresh reset, then a long run to saturate the 3-bit counter.
    @(negedge clk); rst = 1'b0;
    reset_release();
    start = 1'b1; run_n(6); start = 1'b0; run_n(50);
    check("sat_hold_7", 32'(cnt3), 32'd7);
    check("long_run_state", 32'(state), 32'(M_RUN));

    // Asynchronous reset mid-run with start held.
    start = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrun_cpu_en", 32'(cpu_en), 32'd0);
    check("midrun_state", 32'(state), 32'(M_IDLE));
    check("midrun_step_cnt", step_cnt, 32'd0);
    check("midrun_sat_cnt", 32'(cnt3), 32'd0);
    @(negedge clk); start = 1'b0;
    reset_release();
    run_n(20);
    check("post_reset_idle", 32'(state), 32'(M_IDLE));
    check("post_reset_cnt", step_cnt, 32'd0);
    start = 1'b1; run_n(6); start = 1'b0; run_n(4);
    check("restart_run", 32'(state), 32'(M_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
